// File: rtl/ppu_issue_if.sv
// Request/issue/completion bundle between the core, ppu_issue_sched and the PPU pipeline.
// Stat counter signals exist only when PPU_ISSUE_STATS_EN is defined.
interface ppu_issue_if #(
  parameter int OP_SIZE = 3,
  parameter int TAG_W   = 4,
  parameter int DEPTH   = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               in_valid;
  logic               in_ready;
  logic [OP_SIZE-1:0] in_op;
  logic [TAG_W-1:0]   in_tag;
  logic               issue_valid;
  logic [OP_SIZE-1:0] issue_op;
  logic [TAG_W-1:0]   issue_tag;
  logic               out_valid;
  logic [OP_SIZE-1:0] out_op;
  logic [TAG_W-1:0]   out_tag;
  logic               err_o;
  logic               busy;
  logic [CW-1:0]      fifo_count;
`ifdef PPU_ISSUE_STATS_EN
  logic [31:0]        stat_issued;
  logic [31:0]        stat_div;
  logic [31:0]        stat_stall;
`endif

  modport master (
    output in_valid, in_op, in_tag,
    input  in_ready, issue_valid, issue_op, issue_tag, out_valid, out_op, out_tag,
           err_o, busy, fifo_count
`ifdef PPU_ISSUE_STATS_EN
    , input stat_issued, stat_div, stat_stall
`endif
  );

  modport slave (
    input  in_valid, in_op, in_tag,
    output in_ready, issue_valid, issue_op, issue_tag, out_valid, out_op, out_tag,
           err_o, busy, fifo_count
`ifdef PPU_ISSUE_STATS_EN
    , output stat_issued, stat_div, stat_stall
`endif
  );
endinterface

// File: rtl/ppu_issue_sched.sv
// In-order issue scheduler for the PPU pipeline: input FIFO, DIV slot hold, in-flight tracker.
// Optional issue/div/stall counters are enabled with PPU_ISSUE_STATS_EN.
module ppu_issue_sched #(
  parameter int OP_SIZE = 3,
  parameter int TAG_W   = 4,
  parameter int DEPTH   = 4,
  parameter int LAT     = 3
) (
  input logic     clk,
  input logic     rst,
  ppu_issue_if.slave bus
);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
  localparam int NT    = LAT + 2;
  localparam int K_ALU = LAT - 2;
  localparam int K_DIV = LAT - 1;
  localparam logic [OP_SIZE-1:0] OP_DIV       = OP_SIZE'(3);
  localparam logic [OP_SIZE-1:0] OP_MAX_LEGAL = OP_SIZE'(5);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DIV_HOLD = 2'd2} state_t;
  typedef struct packed {
    logic [OP_SIZE-1:0] op;
    logic [TAG_W-1:0]   tag;
  } fifo_t;
  typedef struct packed {
    logic               v;
    logic [OP_SIZE-1:0] op;
    logic [TAG_W-1:0]   tag;
  } trk_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fifo_t         fifo_q [DEPTH];
  fifo_t         fifo_d [DEPTH];
  trk_t          trk_q [NT];
  trk_t          trk_d [NT];
  trk_t          out_q, out_d;

  logic  full_s, empty_s, push_s, pop_s, legal_s, issue_s, err_s, div_s, trk_any_s;
  fifo_t head_s;

  always_comb begin
    full_s  = (count_q == CW'(DEPTH));
    empty_s = (count_q == {CW{1'b0}});
    push_s  = bus.in_valid && !full_s;
    head_s  = fifo_q[rd_ptr_q];
    pop_s   = (state_q == ISSUE) && !empty_s;
    legal_s = (head_s.op <= OP_MAX_LEGAL);
    issue_s = pop_s && legal_s;
    err_s   = pop_s && !legal_s;
    div_s   = issue_s && (head_s.op == OP_DIV);

    count_d  = count_q + CW'(push_s) - CW'(pop_s);
    wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    fifo_d   = fifo_q;
    if (push_s) begin
      fifo_d[wr_ptr_q] = '{op: bus.in_op, tag: bus.in_tag};
    end else begin
      fifo_d[wr_ptr_q] = fifo_q[wr_ptr_q];
    end

    // Tracker shifts toward slot 0; insertion depth sets the result cycle (DIV one deeper).
    for (int i = 0; i < NT - 1; i++) begin
      trk_d[i] = trk_q[i + 1];
    end
    trk_d[NT-1] = '0;
    if (div_s) begin
      trk_d[K_DIV] = '{v: 1'b1, op: head_s.op, tag: head_s.tag};
    end else if (issue_s) begin
      trk_d[K_ALU] = '{v: 1'b1, op: head_s.op, tag: head_s.tag};
    end else begin
      trk_d[K_ALU] = trk_q[K_ALU + 1];
    end
    out_d = trk_q[0];

    trk_any_s = 1'b0;
    for (int i = 0; i < NT; i++) begin
      trk_any_s = trk_any_s | trk_q[i].v;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (count_d != {CW{1'b0}}) state_d = ISSUE;
        else                       state_d = IDLE;
      end
      ISSUE: begin
        if (div_s)                      state_d = DIV_HOLD;
        else if (count_d != {CW{1'b0}}) state_d = ISSUE;
        else                            state_d = IDLE;
      end
      DIV_HOLD: begin
        if (count_d != {CW{1'b0}}) state_d = ISSUE;
        else                       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      for (int i = 0; i < NT; i++)    trk_q[i]  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
      fifo_q   <= fifo_d;
      trk_q    <= trk_d;
    end
  end

  assign bus.in_ready    = !full_s;
  assign bus.issue_valid = issue_s;
  assign bus.issue_op    = issue_s ? head_s.op : {OP_SIZE{1'b0}};
  assign bus.issue_tag   = issue_s ? head_s.tag : {TAG_W{1'b0}};
  assign bus.err_o       = err_s;
  assign bus.out_valid   = out_q.v;
  assign bus.out_op      = out_q.op;
  assign bus.out_tag     = out_q.tag;
  assign bus.busy        = !empty_s || trk_any_s || (state_q != IDLE);
  assign bus.fifo_count  = count_q;

`ifdef PPU_ISSUE_STATS_EN
  logic [31:0] stat_issued_q, stat_issued_d, stat_div_q, stat_div_d, stat_stall_q, stat_stall_d;

  // Counters saturate at all-ones rather than wrapping.
  always_comb begin
    stat_issued_d = stat_issued_q;
    stat_div_d    = stat_div_q;
    stat_stall_d  = stat_stall_q;
    if (issue_s && !(&stat_issued_q)) stat_issued_d = stat_issued_q + 32'd1;
    if (div_s && !(&stat_div_q))      stat_div_d    = stat_div_q + 32'd1;
    if (bus.in_valid && full_s && !(&stat_stall_q)) stat_stall_d = stat_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued_q <= 32'd0;
      stat_div_q    <= 32'd0;
      stat_stall_q  <= 32'd0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_div_q    <= stat_div_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign bus.stat_issued = stat_issued_q;
  assign bus.stat_div    = stat_div_q;
  assign bus.stat_stall  = stat_stall_q;
`endif
endmodule

// File: tb/tb_ppu_issue_sched.sv
// Directed bench for ppu_issue_sched: per-cycle vector table plus DIV-fill and reset sequences.
module tb_ppu_issue_sched;
  localparam int LAT = 3;
  localparam logic [21:0] IDLE_EXP = 22'h1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ppu_issue_if #(.OP_SIZE(3), .TAG_W(4), .DEPTH(4)) bus ();
  ppu_issue_sched #(.OP_SIZE(3), .TAG_W(4), .DEPTH(4), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  typedef struct {
    logic        iv;
    logic [2:0]  op;
    logic [3:0]  tag;
    logic [21:0] exp;
  } vec_t;
  vec_t vecs[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic void add(int iv, int op, int tag, int eiv, int eiop, int eitag,
                              int eov, int eoop, int eotag, int eerr, int ebusy, int ecnt, int erdy);
    vec_t v;
    v.iv  = 1'(iv);
    v.op  = 3'(op);
    v.tag = 4'(tag);
    v.exp = {1'(eiv), 3'(eiop), 4'(eitag), 1'(eov), 3'(eoop), 4'(eotag),
             1'(eerr), 1'(ebusy), 3'(ecnt), 1'(erdy)};
    vecs.push_back(v);
  endfunction

  function automatic logic [21:0] actual();
    return {bus.issue_valid, bus.issue_op, bus.issue_tag, bus.out_valid, bus.out_op, bus.out_tag,
            bus.err_o, bus.busy, bus.fifo_count, bus.in_ready};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic v, logic [2:0] op, logic [3:0] tag);
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_tag   = tag;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushed, issued, done, stalls, maxcnt, last_iss;
    bit saw_full;
    int exp_cyc[$];
    int exp_tag[$];

    // single ADD
    add(1,0,1, 0,0,0, 0,0,0, 0,0,0,1);
    add(0,0,0, 1,0,1, 0,0,0, 0,1,1,1);
    add(0,0,0, 0,0,0, 0,0,0, 0,1,0,1);
    add(0,0,0, 0,0,0, 0,0,0, 0,1,0,1);
    add(0,0,0, 0,0,0, 1,0,1, 0,0,0,1);
    add(0,0,0, 0,0,0, 0,0,0, 0,0,0,1);
    // ADD/2, DIV/3, SUB/4
    add(1,0,2, 0,0,0, 0,0,0, 0,0,0,1);
    add(1,3,3, 1,0,2, 0,0,0, 0,1,1,1);
    add(1,1,4, 1,3,3, 0,0,0, 0,1,1,1);
    add(0,0,0, 0,0,0, 0,0,0, 0,1,1,1);
    add(0,0,0, 1,1,4, 1,0,2, 0,1,1,1);
    add(0,0,0, 0,0,0, 0,0,0, 0,1,0,1);
    add(0,0,0, 0,0,0, 1,3,3, 0,1,0,1);
    add(0,0,0, 0,0,0, 1,1,4, 0,0,0,1);
    add(0,0,0, 0,0,0, 0,0,0, 0,0,0,1);
    // illegal opcode 6/5 then MUL/6
    add(1,6,5, 0,0,0, 0,0,0, 0,0,0,1);
    add(1,2,6, 0,0,0, 0,0,0, 1,1,1,1);
    add(0,0,0, 1,2,6, 0,0,0, 0,1,1,1);
    add(0,0,0, 0,0,0, 0,0,0, 0,1,0,1);
    add(0,0,0, 0,0,0, 0,0,0, 0,1,0,1);
    add(0,0,0, 0,0,0, 1,2,6, 0,0,0,1);
    add(0,0,0, 0,0,0, 0,0,0, 0,0,0,1);

    rst = 1'b1;
    drive(1'b0, 3'd0, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", 32'(actual()), 32'(IDLE_EXP));
    rst = 1'b0;

    foreach (vecs[i]) begin
      next_cycle();
      drive(vecs[i].iv, vecs[i].op, vecs[i].tag);
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(actual()), 32'(vecs[i].exp));
    end

    // DIV fill: keep in_valid high until 8 DIVs are accepted
    next_cycle();
    drive(1'b0, 3'd0, 4'd0);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    pushed = 0; issued = 0; done = 0; stalls = 0; maxcnt = 0; last_iss = -1; saw_full = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (c > 0) next_cycle();
      drive(pushed < 8, 3'd3, 4'(pushed));
      @(negedge clk);
      if (int'(bus.fifo_count) > maxcnt) maxcnt = int'(bus.fifo_count);
      if (bus.in_valid && !bus.in_ready) begin
        stalls++;
        saw_full = 1'b1;
      end
      if (bus.in_valid && bus.in_ready) pushed++;
      if (bus.issue_valid) begin
        check("fill_issue_tag", 32'({bus.issue_op, bus.issue_tag}), 32'({3'd3, 4'(issued)}));
        if (last_iss >= 0) check("fill_issue_gap", 32'(c - last_iss), 32'd2);
        last_iss = c;
        exp_cyc.push_back(c + LAT + 1);
        exp_tag.push_back(issued);
        issued++;
      end
      if (bus.out_valid) begin
        if (exp_tag.size() == 0) begin
          check("fill_spurious_out", 32'(bus.out_tag), 32'hFFFF_FFFF);
        end else begin
          check("fill_out_tag", 32'(bus.out_tag), 32'(exp_tag.pop_front()));
          check("fill_out_cycle", 32'(c), 32'(exp_cyc.pop_front()));
        end
        done++;
      end
      if (pushed == 8 && done == 8 && !bus.busy) break;
    end
    drive(1'b0, 3'd0, 4'd0);
    check("fill_max_count", 32'(maxcnt), 32'd4);
    check("fill_saw_full", 32'(saw_full), 32'd1);
    check("fill_issued", 32'(issued), 32'd8);
    check("fill_done", 32'(done), 32'd8);
`ifdef PPU_ISSUE_STATS_EN
    check("stat_issued", bus.stat_issued, 32'd8);
    check("stat_div", bus.stat_div, 32'd8);
    check("stat_stall", bus.stat_stall, 32'(stalls));
`endif

    // reset while ops are in flight
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      drive(1'b1, 3'd0, 4'(9 + c));
    end
    next_cycle();
    drive(1'b0, 3'd0, 4'd0);
    rst = 1'b1;
    @(negedge clk);
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_state", 32'(actual()), 32'(IDLE_EXP));
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      @(negedge clk);
      check("post_reset_no_out", 32'(bus.out_valid), 32'd0);
    end
    next_cycle();
    drive(1'b1, 3'd0, 4'd12);
    next_cycle();
    drive(1'b0, 3'd0, 4'd0);
    @(negedge clk);
    check("post_reset_issue", 32'({bus.issue_valid, bus.issue_op, bus.issue_tag}), 32'({1'b1, 3'd0, 4'd12}));
    repeat (3) next_cycle();
    @(negedge clk);
    check("post_reset_out", 32'({bus.out_valid, bus.out_op, bus.out_tag}), 32'({1'b1, 3'd0, 4'd12}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
